// File: rtl/beta_ctrl_pkg.sv
// Shared encodings for the BETA multicycle control: FSM states, opcode constants,
// PCSEL/WDSEL mux encodings and the opcode class enum used by the decoder.
package beta_ctrl_pkg;

  localparam logic [4:0] XP_REG      = 5'd30;
  localparam int         MEM_TIMEOUT = 0;

  localparam logic [5:0] OPC_LD  = 6'h18;
  localparam logic [5:0] OPC_ST  = 6'h19;
  localparam logic [5:0] OPC_JMP = 6'h1B;
  localparam logic [5:0] OPC_BEQ = 6'h1C;
  localparam logic [5:0] OPC_BNE = 6'h1D;
  localparam logic [5:0] OPC_LDR = 6'h1F;

  localparam logic [2:0] PCSEL_INC   = 3'd0;
  localparam logic [2:0] PCSEL_BR    = 3'd1;
  localparam logic [2:0] PCSEL_JMP   = 3'd2;
  localparam logic [2:0] PCSEL_ILLOP = 3'd3;
  localparam logic [2:0] PCSEL_XADR  = 3'd4;

  localparam logic [1:0] WDSEL_PC4 = 2'd0;
  localparam logic [1:0] WDSEL_ALU = 2'd1;
  localparam logic [1:0] WDSEL_MEM = 2'd2;

  typedef enum logic [2:0] {
    ST_RST,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_OP,
    CLS_LD,
    CLS_ST,
    CLS_JMP,
    CLS_BEQ,
    CLS_BNE,
    CLS_LDR,
    CLS_ILL
  } op_class_t;

endpackage

// File: rtl/beta_op_decode.sv
// Combinational opcode classifier: maps IR[31:26] to an instruction class and a
// legal flag. OP/OPC covers every opcode with bit 5 set except function codes 7 and F.
module beta_op_decode
  import beta_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  cls,
  output logic       legal
);

  always_comb begin
    cls = CLS_ILL;
    case (opcode)
      OPC_LD:  cls = CLS_LD;
      OPC_ST:  cls = CLS_ST;
      OPC_JMP: cls = CLS_JMP;
      OPC_BEQ: cls = CLS_BEQ;
      OPC_BNE: cls = CLS_BNE;
      OPC_LDR: cls = CLS_LDR;
      default: begin
        if (opcode[5] && (opcode[3:0] != 4'h7) && (opcode[3:0] != 4'hF))
          cls = CLS_OP;
      end
    endcase
    legal = (cls != CLS_ILL);
  end

endmodule

// File: rtl/beta_mc_control.sv
// Multicycle control FSM for the BETA datapath (fetch/decode/exec/mem/trap over one
// memory port). Optional interrupt trap in DECODE is enabled by defining BETA_IRQ_EN.
module beta_mc_control
  import beta_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       z,
  input  logic       irq,
  input  logic       pc_super,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_load,
  output logic       pc_load,
  output logic [2:0] pcsel,
  output logic       asel,
  output logic       bsel,
  output logic       ra2sel,
  output logic [1:0] wdsel,
  output logic       werf,
  output logic       wasel,
  output logic [3:0] alu_op
);

  state_t    state, state_next;
  op_class_t cls;
  logic      legal;
  logic      irq_take;
  logic      trap_irq;

  beta_op_decode u_decode (
    .opcode (opcode),
    .cls    (cls),
    .legal  (legal)
  );

`ifdef BETA_IRQ_EN
  assign irq_take = irq && !pc_super;
`else
  logic unused_irq;
  assign irq_take   = 1'b0;
  assign unused_irq = &{1'b0, irq, pc_super};
`endif

  // trap_irq remembers why DECODE went to TRAP so the vector can be chosen there
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_RST;
      trap_irq <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_DECODE)
        trap_irq <= irq_take;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RST:    state_next = ST_FETCH;
      ST_FETCH:  if (mem_ack) state_next = ST_DECODE;
      ST_DECODE: state_next = (irq_take || !legal) ? ST_TRAP : ST_EXEC;
      ST_EXEC:   state_next = (cls == CLS_LD || cls == CLS_ST || cls == CLS_LDR) ? ST_MEM : ST_FETCH;
      ST_MEM:    if (mem_ack) state_next = ST_FETCH;
      ST_TRAP:   state_next = ST_FETCH;
      default:   state_next = ST_RST;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_load = 1'b0;
    pc_load = 1'b0;
    pcsel   = PCSEL_INC;
    asel    = 1'b0;
    bsel    = 1'b0;
    ra2sel  = 1'b0;
    wdsel   = WDSEL_PC4;
    werf    = 1'b0;
    wasel   = 1'b0;
    alu_op  = 4'h0;
    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ack;
      end
      ST_EXEC: begin
        case (cls)
          CLS_OP: begin
            pc_load = 1'b1;
            werf    = 1'b1;
            wdsel   = WDSEL_ALU;
            bsel    = opcode[4];
            alu_op  = opcode[3:0];
          end
          CLS_JMP: begin
            pc_load = 1'b1;
            werf    = 1'b1;
            pcsel   = PCSEL_JMP;
          end
          CLS_BEQ, CLS_BNE: begin
            pc_load = 1'b1;
            werf    = 1'b1;
            if ((cls == CLS_BEQ) ? z : !z)
              pcsel = PCSEL_BR;
          end
          default: ;
        endcase
      end
      // Address/data selects stay put for the whole wait so memory sees a stable request
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls == CLS_ST);
        bsel    = (cls == CLS_LD) || (cls == CLS_ST);
        asel    = (cls == CLS_LDR);
        ra2sel  = (cls == CLS_ST);
        if (mem_ack) begin
          pc_load = 1'b1;
          if (cls != CLS_ST) begin
            werf  = 1'b1;
            wdsel = WDSEL_MEM;
          end
        end
      end
      ST_TRAP: begin
        werf    = 1'b1;
        wasel   = 1'b1;
        pc_load = 1'b1;
        pcsel   = trap_irq ? PCSEL_XADR : PCSEL_ILLOP;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_beta_mc_control.sv
// Self-checking bench for beta_mc_control: table of instructions walked through
// fetch/decode/exec/mem, plus reset-abort and interrupt sequences.
module tb_beta_mc_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       z, irq, pc_super, mem_ack;
  logic       mem_req, mem_we, ir_load, pc_load, asel, bsel, ra2sel, werf, wasel;
  logic [2:0] pcsel;
  logic [1:0] wdsel;
  logic [3:0] alu_op;

  always #5 clk = ~clk;

  beta_mc_control dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .opcode   (opcode),
    .z        (z),
    .irq      (irq),
    .pc_super (pc_super),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .ir_load  (ir_load),
    .pc_load  (pc_load),
    .pcsel    (pcsel),
    .asel     (asel),
    .bsel     (bsel),
    .ra2sel   (ra2sel),
    .wdsel    (wdsel),
    .werf     (werf),
    .wasel    (wasel),
    .alu_op   (alu_op)
  );

  typedef struct packed {
    logic       mem_req, mem_we, ir_load, pc_load;
    logic [2:0] pcsel;
    logic       asel, bsel, ra2sel;
    logic [1:0] wdsel;
    logic       werf, wasel;
    logic [3:0] alu_op;
  } out_t;

  // kind: 0 = completes in EXEC, 1 = goes through MEM, 2 = traps
  typedef struct {
    logic [5:0] opcode;
    logic       z, irq, pc_super, noise;
    int         fetch_waits, mem_waits, kind;
    out_t       exp_main, exp_wait, exp_ack;
  } vec_t;

  out_t  sb_q[$];
  string tag_q[$];
  vec_t  vecs[$];
  int    checks = 0;
  int    passes = 0;

  function automatic out_t mk(logic req, logic we, logic irl, logic pcl, logic [2:0] ps,
                              logic as, logic bs, logic r2, logic [1:0] wd,
                              logic wf, logic wa, logic [3:0] alu);
    return {req, we, irl, pcl, ps, as, bs, r2, wd, wf, wa, alu};
  endfunction

  function automatic vec_t mkv(int kind, logic [5:0] op, logic zz, int fw, int mw,
                               out_t m, out_t w, out_t a);
    vec_t v;
    v.kind = kind; v.opcode = op; v.z = zz; v.fetch_waits = fw; v.mem_waits = mw;
    v.irq = 1'b0; v.pc_super = 1'b0; v.noise = 1'b0;
    v.exp_main = m; v.exp_wait = w; v.exp_ack = a;
    return v;
  endfunction

  localparam out_t ZERO   = '0;
  localparam out_t F_WAIT = 18'b1_0_0_0_000_0_0_0_00_0_0_0000;
  localparam out_t F_ACK  = 18'b1_0_1_0_000_0_0_0_00_0_0_0000;

  task automatic checkOutput();
    out_t  act, exp;
    string tag;
    act = {mem_req, mem_we, ir_load, pc_load, pcsel, asel, bsel, ra2sel, wdsel, werf, wasel, alu_op};
    checks++;
    if (sb_q.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty: got %h, nothing expected", act);
    end else begin
      exp = sb_q.pop_front();
      tag = tag_q.pop_front();
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h required %h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ack, input out_t exp, input string tag);
    mem_ack = ack;
    sb_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic runVec(input int i);
    vec_t v;
    v = vecs[i];
    irq = v.irq;
    pc_super = v.pc_super;
    for (int w = 0; w < v.fetch_waits; w++)
      applyStimulus(1'b0, F_WAIT, $sformatf("v%0d_fetch_wait", i));
    applyStimulus(1'b1, F_ACK, $sformatf("v%0d_fetch_ack", i));
    opcode = v.opcode;
    z = v.z;
    applyStimulus(v.noise, ZERO, $sformatf("v%0d_decode", i));
    if (v.kind == 1) begin
      applyStimulus(v.noise, ZERO, $sformatf("v%0d_exec_addr", i));
      for (int w = 0; w < v.mem_waits; w++)
        applyStimulus(1'b0, v.exp_wait, $sformatf("v%0d_mem_wait", i));
      applyStimulus(1'b1, v.exp_ack, $sformatf("v%0d_mem_ack", i));
    end else begin
      applyStimulus(v.noise, v.exp_main, $sformatf("v%0d_%s", i, (v.kind == 2) ? "trap" : "exec"));
    end
    irq = 1'b0;
    pc_super = 1'b0;
  endtask

  initial begin
    vec_t v;
    out_t ld_wait;
    reset_n = 1'b0; opcode = 6'h00; z = 1'b0; irq = 1'b0; pc_super = 1'b0; mem_ack = 1'b0;

    //                 req we irl pcl ps as bs r2 wd wf wa alu
    vecs.push_back(mkv(0, 6'h30, 0, 1, 0, mk(0,0,0,1,0,0,1,0,1,1,0,4'h0), ZERO, ZERO)); // ADDC
    vecs.push_back(mkv(0, 6'h20, 0, 0, 0, mk(0,0,0,1,0,0,0,0,1,1,0,4'h0), ZERO, ZERO)); // ADD
    v = mkv(0, 6'h31, 0, 2, 0, mk(0,0,0,1,0,0,1,0,1,1,0,4'h1), ZERO, ZERO);             // SUBC, stray acks
    v.noise = 1'b1;
    vecs.push_back(v);
    vecs.push_back(mkv(0, 6'h26, 0, 0, 0, mk(0,0,0,1,0,0,0,0,1,1,0,4'h6), ZERO, ZERO)); // CMPLE
    vecs.push_back(mkv(0, 6'h1C, 1, 0, 0, mk(0,0,0,1,1,0,0,0,0,1,0,4'h0), ZERO, ZERO)); // BEQ z=1
    vecs.push_back(mkv(0, 6'h1D, 1, 0, 0, mk(0,0,0,1,0,0,0,0,0,1,0,4'h0), ZERO, ZERO)); // BNE z=1
    vecs.push_back(mkv(0, 6'h1C, 0, 0, 0, mk(0,0,0,1,0,0,0,0,0,1,0,4'h0), ZERO, ZERO)); // BEQ z=0
    vecs.push_back(mkv(0, 6'h1D, 0, 0, 0, mk(0,0,0,1,1,0,0,0,0,1,0,4'h0), ZERO, ZERO)); // BNE z=0
    vecs.push_back(mkv(0, 6'h1B, 0, 0, 0, mk(0,0,0,1,2,0,0,0,0,1,0,4'h0), ZERO, ZERO)); // JMP
    vecs.push_back(mkv(1, 6'h18, 0, 0, 0, ZERO, mk(1,0,0,0,0,0,1,0,0,0,0,4'h0),
                                               mk(1,0,0,1,0,0,1,0,2,1,0,4'h0)));        // LD
    vecs.push_back(mkv(1, 6'h19, 0, 1, 3, ZERO, mk(1,1,0,0,0,0,1,1,0,0,0,4'h0),
                                               mk(1,1,0,1,0,0,1,1,0,0,0,4'h0)));        // ST
    vecs.push_back(mkv(1, 6'h1F, 0, 0, 1, ZERO, mk(1,0,0,0,0,1,0,0,0,0,0,4'h0),
                                               mk(1,0,0,1,0,1,0,0,2,1,0,4'h0)));        // LDR
    vecs.push_back(mkv(2, 6'h00, 0, 0, 0, mk(0,0,0,1,3,0,0,0,0,1,1,4'h0), ZERO, ZERO)); // illegal
    vecs.push_back(mkv(2, 6'h27, 0, 0, 0, mk(0,0,0,1,3,0,0,0,0,1,1,4'h0), ZERO, ZERO));
    vecs.push_back(mkv(2, 6'h3F, 0, 0, 0, mk(0,0,0,1,3,0,0,0,0,1,1,4'h0), ZERO, ZERO));
    vecs.push_back(mkv(2, 6'h1A, 0, 0, 0, mk(0,0,0,1,3,0,0,0,0,1,1,4'h0), ZERO, ZERO));
`ifdef BETA_IRQ_EN
    v = mkv(2, 6'h20, 0, 0, 0, mk(0,0,0,1,4,0,0,0,0,1,1,4'h0), ZERO, ZERO);
`else
    v = mkv(0, 6'h20, 0, 0, 0, mk(0,0,0,1,0,0,0,0,1,1,0,4'h0), ZERO, ZERO);
`endif
    v.irq = 1'b1;
    vecs.push_back(v);
    v = mkv(0, 6'h20, 0, 0, 0, mk(0,0,0,1,0,0,0,0,1,1,0,4'h0), ZERO, ZERO);            // masked irq
    v.irq = 1'b1; v.pc_super = 1'b1;
    vecs.push_back(v);
    vecs.push_back(mkv(0, 6'h30, 0, 0, 0, mk(0,0,0,1,0,0,1,0,1,1,0,4'h0), ZERO, ZERO)); // after irq

    @(posedge clk); #1;
    applyStimulus(1'b1, ZERO, "reset_hold");
    reset_n = 1'b1;
    applyStimulus(1'b0, ZERO, "reset_release");

    for (int i = 0; i < vecs.size(); i++)
      runVec(i);

    // Reset lands in the middle of an LD memory wait
    ld_wait = mk(1,0,0,0,0,0,1,0,0,0,0,4'h0);
    applyStimulus(1'b1, F_ACK, "abort_fetch_ack");
    opcode = 6'h18;
    applyStimulus(1'b0, ZERO, "abort_decode");
    applyStimulus(1'b0, ZERO, "abort_exec");
    applyStimulus(1'b0, ld_wait, "abort_mem_wait");
    reset_n = 1'b0;
    applyStimulus(1'b0, ld_wait, "abort_mem_reset_edge");
    reset_n = 1'b1;
    applyStimulus(1'b1, ZERO, "abort_rst_state");
    applyStimulus(1'b0, F_WAIT, "abort_refetch");
    applyStimulus(1'b1, F_ACK, "abort_refetch_ack");

    if (sb_q.size() != 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
